instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Fetch stage of the MIPS core. Owns the program counter that drives ProgramMemory's Address
//   input and registers the returned Instruction into the IF/ID pipeline register.
//   Handles next-PC selection: sequential, branch, jump and jump-register. Handles stall (hold)
//   and flush (bubble) requests from later stages.
// PARAMETERS
//   DATA_WIDTH    32     width of PC, addresses and instructions
//   MEMORY_DEPTH  32     ProgramMemory depth in words; used for range check
//   RESET_PC      32'h0  PC value loaded on reset; must be word aligned
// PORTS
//   clk              in   1           rising-edge clock
//   reset            in   1           synchronous, active-high reset
//   Instruction      in   DATA_WIDTH  word read from ProgramMemory at PC (combinational)
//   Stall            in   1           hold PC and IF/ID (load-use hazard)
//   Flush            in   1           replace next IF/ID contents with bubble
//   BranchTaken      in   1           redirect to BranchTarget
//   BranchTarget     in   DATA_WIDTH  branch destination byte address
//   Jump             in   1           redirect to JumpTarget (J/JAL)
//   JumpTarget       in   DATA_WIDTH  jump destination byte address
//   JumpRegister     in   1           redirect to JRTarget (JR)
//   JRTarget         in   DATA_WIDTH  register-sourced destination
//   PC               out  DATA_WIDTH  current fetch address, to ProgramMemory Address
//   IFID_Instruction out  DATA_WIDTH  registered instruction; 0 (NOP) when bubble
//   IFID_PCPlus4     out  DATA_WIDTH  registered PC+4 of that instruction
//   IFID_Valid       out  1           IF/ID holds a real instruction
//   MisalignedTarget out  1           registered 1-cycle pulse: taken redirect had addr[1:0]!=0
//   PCOutOfRange     out  1           combinational: PC >= MEMORY_DEPTH*4
// BEHAVIOUR
//   - Reset (sync, sampled at clk edge) has highest priority:
//     PC=RESET_PC, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, MisalignedTarget=0.
//   - Redirect is any of JumpRegister, Jump or BranchTaken. Next-PC priority:
//     JumpRegister > Jump > BranchTaken > Stall (hold) > PC+4.
//   - The selected redirect target is loaded with bits [1:0] forced to 00.
//     MisalignedTarget is set for exactly one cycle if the original bits were nonzero.
//   - A redirect overrides Stall: PC loads the target even when Stall=1.
//   - IF/ID update, same priority:
//       redirect or Flush -> Instruction=0, Valid=0, PCPlus4 held;
//       else Stall        -> all IF/ID fields held;
//       else              -> Instruction<=Instruction, PCPlus4<=PC+4, Valid<=1.
//   - Flush alone (no redirect) does not stop PC: PC still advances to PC+4, or holds if Stall.
//   - Latency: the word at PC appears on IFID_Instruction at the next clk edge; one fetch per cycle.
//   - PC+4 is computed modulo 2^DATA_WIDTH. 0xFFFFFFFC wraps to 0 with no flag.
//   - PCOutOfRange is advisory only; fetch continues. ProgramMemory indexes by PC>>2.
//   - Reset asserted mid-stall or mid-redirect wins on that edge. No pending state survives reset.
//   - Single always block for the registers; next-PC mux is combinational.
// CONFIGURATION
//   FETCH_PERF_CNT_EN defined: adds three outputs, each 32-bit and saturating at 32'hFFFFFFFF:
//     FetchCount  +1 on each cycle IF/ID loads a valid instruction
//     StallCount  +1 on each cycle Stall=1 with no redirect
//     FlushCount  +1 on each cycle the bubble is inserted
//     All three clear on reset.
//   Not defined: these ports and counters do not exist; all other behaviour is identical.
// TESTING
//   1 reset=1 for 2 cycles, then release, ProgramMemory holding 0..7
//     -> PC: 0,4,8,12...; IFID_Valid=0 the first cycle after release, then 1;
//        IFID_PCPlus4 = 4,8,12...
//   2 Stall=1 for 3 cycles at PC=8
//     -> PC stays 8 and IF/ID held for those 3 cycles; PC=12 on the cycle after Stall drops.
//   3 BranchTaken=1, BranchTarget=0x40, with Stall=1 in the same cycle
//     -> next PC=0x40, IFID_Instruction=0, IFID_Valid=0; the following cycle fetches word 16.
//   4 Jump=1/0x20 and JumpRegister=1/0x30 asserted together
//     -> PC=0x30, not 0x20.
//   5 JRTarget=0x13 with JumpRegister=1
//     -> PC=0x10; MisalignedTarget=1 for exactly one cycle.
//   6 PC=0xFFFFFFFC, no control asserted -> next PC=0;
//     PCOutOfRange=1 at 0xFFFFFFFC and 0 at 0.
//     With FETCH_PERF_CNT_EN, FetchCount preset to 32'hFFFFFFFF stays at 32'hFFFFFFFF.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC register, next-PC select (JR > J > branch > stall > +4), IF/ID register.
// One fetch per cycle, word at PC lands in IF/ID next edge; optional counters under FETCH_PERF_CNT_EN.
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Instruction,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  BranchTaken,
  input  logic [DATA_WIDTH-1:0] BranchTarget,
  input  logic                  Jump,
  input  logic [DATA_WIDTH-1:0] JumpTarget,
  input  logic                  JumpRegister,
  input  logic [DATA_WIDTH-1:0] JRTarget,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] IFID_Instruction,
  output logic [DATA_WIDTH-1:0] IFID_PCPlus4,
  output logic                  IFID_Valid,
  output logic                  MisalignedTarget,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]           FetchCount,
  output logic [31:0]           StallCount,
  output logic [31:0]           FlushCount,
`endif
  output logic                  PCOutOfRange
);

  localparam logic [DATA_WIDTH-1:0] PC_LIMIT = DATA_WIDTH'(MEMORY_DEPTH * 4);

  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ifid_instr_q, ifid_instr_d;
  logic [DATA_WIDTH-1:0] ifid_pcp4_q, ifid_pcp4_d;
  logic                  ifid_valid_q, ifid_valid_d;
  logic                  misaligned_q, misaligned_d;
  logic                  redirect, bubble, load_valid;
  logic [DATA_WIDTH-1:0] raw_target, pc_plus4;

  always_comb begin
    redirect   = JumpRegister | Jump | BranchTaken;
    bubble     = redirect | Flush;
    load_valid = ~bubble & ~Stall;
    pc_plus4   = pc_q + DATA_WIDTH'(4);

    raw_target = BranchTarget;
    if (JumpRegister) raw_target = JRTarget;
    else if (Jump)    raw_target = JumpTarget;

    // Redirect wins over Stall; Flush alone never stops the PC.
    if (redirect)   pc_d = {raw_target[DATA_WIDTH-1:2], 2'b00};
    else if (Stall) pc_d = pc_q;
    else            pc_d = pc_plus4;
    misaligned_d = redirect & (|raw_target[1:0]);

    ifid_instr_d = ifid_instr_q;
    ifid_pcp4_d  = ifid_pcp4_q;
    ifid_valid_d = ifid_valid_q;
    if (bubble) begin
      ifid_instr_d = '0;
      ifid_valid_d = 1'b0;
    end else if (!Stall) begin
      ifid_instr_d = Instruction;
      ifid_pcp4_d  = pc_plus4;
      ifid_valid_d = 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (load_valid && fetch_cnt_q != '1)           fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (Stall && !redirect && stall_cnt_q != '1)   stall_cnt_d = stall_cnt_q + 32'd1;
    if (bubble && flush_cnt_q != '1)               flush_cnt_d = flush_cnt_q + 32'd1;
  end

  assign FetchCount = fetch_cnt_q;
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      ifid_instr_q <= '0;
      ifid_pcp4_q  <= '0;
      ifid_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
      fetch_cnt_q  <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
`endif
    end else begin
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pcp4_q  <= ifid_pcp4_d;
      ifid_valid_q <= ifid_valid_d;
      misaligned_q <= misaligned_d;
`ifdef FETCH_PERF_CNT_EN
      fetch_cnt_q  <= fetch_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
`endif
    end
  end

  assign PC               = pc_q;
  assign IFID_Instruction = ifid_instr_q;
  assign IFID_PCPlus4     = ifid_pcp4_q;
  assign IFID_Valid       = ifid_valid_q;
  assign MisalignedTarget = misaligned_q;
  assign PCOutOfRange     = (pc_q >= PC_LIMIT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: vector table plus reset-priority sequence.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        stall, flush, br, jmp, jr;
  logic [31:0] brt, jt, jrt;
  logic [31:0] pc, ifid_instr, ifid_pcp4;
  logic        ifid_valid, mis, oor;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Program memory model: word n holds 0xA0000000 | n, so word 0 is distinguishable from a bubble.
  assign instr = 32'hA000_0000 | (pc >> 2);

  instruction_fetch_unit #(.DATA_WIDTH(32), .MEMORY_DEPTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .Instruction(instr),
    .Stall(stall), .Flush(flush),
    .BranchTaken(br), .BranchTarget(brt),
    .Jump(jmp), .JumpTarget(jt),
    .JumpRegister(jr), .JRTarget(jrt),
    .PC(pc), .IFID_Instruction(ifid_instr), .IFID_PCPlus4(ifid_pcp4),
    .IFID_Valid(ifid_valid), .MisalignedTarget(mis),
`ifdef FETCH_PERF_CNT_EN
    .FetchCount(fetch_cnt), .StallCount(stall_cnt), .FlushCount(flush_cnt),
`endif
    .PCOutOfRange(oor)
  );

  typedef struct {
    logic [4:0]  ctrl;   // {stall, flush, br, jmp, jr}
    logic [31:0] brt, jt, jrt;
    logic [31:0] pc, ins, p4;
    logic [2:0]  flags;  // {valid, misaligned, out_of_range}
  } vec_t;

  function automatic vec_t mk(input logic [4:0] c, input logic [31:0] b, input logic [31:0] j,
                              input logic [31:0] r, input logic [31:0] p, input logic [31:0] i,
                              input logic [31:0] f4, input logic [2:0] fl);
    vec_t v;
    v.ctrl = c; v.brt = b; v.jt = j; v.jrt = r;
    v.pc = p; v.ins = i; v.p4 = f4; v.flags = fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, " pc"},    pc,         v.pc);
    chk({tag, " instr"}, ifid_instr, v.ins);
    chk({tag, " pcp4"},  ifid_pcp4,  v.p4);
    chk({tag, " valid"}, {31'd0, ifid_valid}, {31'd0, v.flags[2]});
    chk({tag, " mis"},   {31'd0, mis},        {31'd0, v.flags[1]});
    chk({tag, " oor"},   {31'd0, oor},        {31'd0, v.flags[0]});
  endtask

  vec_t vecs[19];

  initial begin
    vecs[0]  = mk(5'b00000, 32'h0,   32'h0,   32'h0,        32'h4,        32'hA000_0000, 32'h4,  3'b100);
    vecs[1]  = mk(5'b00000, 32'h0,   32'h0,   32'h0,        32'h8,        32'hA000_0001, 32'h8,  3'b100);
    vecs[2]  = mk(5'b10000, 32'h0,   32'h0,   32'h0,        32'h8,        32'hA000_0001, 32'h8,  3'b100);
    vecs[3]  = mk(5'b10000, 32'h0,   32'h0,   32'h0,        32'h8,        32'hA000_0001, 32'h8,  3'b100);
    vecs[4]  = mk(5'b10000, 32'h0,   32'h0,   32'h0,        32'h8,        32'hA000_0001, 32'h8,  3'b100);
    vecs[5]  = mk(5'b00000, 32'h0,   32'h0,   32'h0,        32'hC,        32'hA000_0002, 32'hC,  3'b100);
    vecs[6]  = mk(5'b10100, 32'h40,  32'h0,   32'h0,        32'h40,       32'h0,         32'hC,  3'b000);
    vecs[7]  = mk(5'b00000, 32'h0,   32'h0,   32'h0,        32'h44,       32'hA000_0010, 32'h44, 3'b100);
    vecs[8]  = mk(5'b00011, 32'h0,   32'h20,  32'h30,       32'h30,       32'h0,         32'h44, 3'b000);
    vecs[9]  = mk(5'b00001, 32'h0,   32'h0,   32'h13,       32'h10,       32'h0,         32'h44, 3'b010);
    vecs[10] = mk(5'b00000, 32'h0,   32'h0,   32'h0,        32'h14,       32'hA000_0004, 32'h14, 3'b100);
    vecs[11] = mk(5'b01000, 32'h0,   32'h0,   32'h0,        32'h18,       32'h0,         32'h14, 3'b000);
    vecs[12] = mk(5'b11000, 32'h0,   32'h0,   32'h0,        32'h18,       32'h0,         32'h14, 3'b000);
    vecs[13] = mk(5'b00000, 32'h0,   32'h0,   32'h0,        32'h1C,       32'hA000_0006, 32'h1C, 3'b100);
    vecs[14] = mk(5'b00001, 32'h0,   32'h0,   32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,        32'h1C, 3'b001);
    vecs[15] = mk(5'b00000, 32'h0,   32'h0,   32'h0,        32'h0,        32'hBFFF_FFFF, 32'h0,  3'b100);
    vecs[16] = mk(5'b00100, 32'h80,  32'h0,   32'h0,        32'h80,       32'h0,         32'h0,  3'b001);
    vecs[17] = mk(5'b00100, 32'h7E,  32'h0,   32'h0,        32'h7C,       32'h0,         32'h0,  3'b010);
    vecs[18] = mk(5'b10110, 32'h200, 32'h101, 32'h0,        32'h100,      32'h0,         32'h0,  3'b011);

    reset = 1'b1;
    {stall, flush, br, jmp, jr} = 5'b00000;
    brt = '0; jt = '0; jrt = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", mk(5'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000));
    reset = 1'b0;

    for (int i = 0; i < 19; i++) begin
      {stall, flush, br, jmp, jr} = vecs[i].ctrl;
      brt = vecs[i].brt; jt = vecs[i].jt; jrt = vecs[i].jrt;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset asserted together with stall and a misaligned redirect must win outright.
    {stall, flush, br, jmp, jr} = 5'b10001;
    jrt = 32'h33;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_mid", mk(5'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 3'b000));
    reset = 1'b0;
    {stall, flush, br, jmp, jr} = 5'b00000;
    jrt = '0;
    @(posedge clk);
    #1;
    check_all("post_rst", mk(5'b0, 32'h0, 32'h0, 32'h0, 32'h4, 32'hA000_0000, 32'h4, 3'b100));
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, 32'd1);
    chk("stall_cnt", stall_cnt, 32'd0);
    chk("flush_cnt", flush_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
